// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider: q = a / b via a registered reciprocal of b
// followed by a rounded multiply. Denormals flush to zero; specials override the product.
module fp_div_seq #(
  parameter int unsigned RECIP_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] q,
  output logic        flag_dz,
  output logic        flag_inv
);

  typedef enum logic [1:0] {StIdle, StRecip, StMul, StDone} state_e;

  localparam logic [49:0] RecipNum = 50'd1 << 49;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, r_q, r_d, q_q, q_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dz_q, dz_d, inv_q, inv_d;

  // Reciprocal of b_q: 2^49 / 1.mb gives 26 quotient bits, enough for a rounded 24-bit mantissa.
  logic [49:0]       recip_full;
  logic signed [9:0] recip_e;
  logic [31:0]       recip;

  assign recip_full = RecipNum / {26'b0, 1'b1, b_q[22:0]};

  always_comb begin
    recip = '0;
    if (b_q[22:0] == 23'd0) begin
      recip_e = 10'sd254 - $signed({2'b0, b_q[30:23]});
      if (recip_e > 10'sd0) recip = {1'b0, recip_e[7:0], 23'd0};
    end else begin
      recip_e = 10'sd253 - $signed({2'b0, b_q[30:23]});
      if (recip_e > 10'sd0) begin
        recip = {1'b0, recip_e[7:0], recip_full[24:2]} + {31'd0, recip_full[1]};
      end
    end
  end

  // Multiplier a_q * r_q, round-half-up; carry out of the mantissa rolls into the exponent.
  logic [47:0]       prod;
  logic signed [9:0] prod_e;
  logic [22:0]       prod_m;
  logic              prod_rnd;
  logic [30:0]       mul_mag;

  assign prod = {1'b1, a_q[22:0]} * {1'b1, r_q[22:0]};

  always_comb begin
    prod_e = $signed({2'b0, a_q[30:23]}) + $signed({2'b0, r_q[30:23]}) - 10'sd127
           + $signed({9'd0, prod[47]});
    prod_m   = prod[47] ? prod[46:24] : prod[45:23];
    prod_rnd = prod[47] ? prod[23] : prod[22];
    mul_mag  = '0;
    if (a_q[30:23] == 8'd0 || r_q[30:23] == 8'd0) begin
      mul_mag = '0;
    end else if (prod_e >= 10'sd255) begin
      mul_mag = {8'hFF, 23'd0};
    end else if (prod_e > 10'sd0) begin
      mul_mag = {prod_e[7:0], prod_m} + {30'd0, prod_rnd};
    end
  end

  logic        sgn, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [31:0] res_q;
  logic        res_dz, res_inv;

  always_comb begin
    sgn    = a_q[31] ^ b_q[31];
    a_zero = a_q[30:23] == 8'h00;
    b_zero = b_q[30:23] == 8'h00;
    a_inf  = a_q[30:23] == 8'hFF && a_q[22:0] == 23'd0;
    b_inf  = b_q[30:23] == 8'hFF && b_q[22:0] == 23'd0;
    a_nan  = a_q[30:23] == 8'hFF && a_q[22:0] != 23'd0;
    b_nan  = b_q[30:23] == 8'hFF && b_q[22:0] != 23'd0;
    res_q   = {sgn, mul_mag};
    res_dz  = 1'b0;
    res_inv = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      res_q   = 32'h7FC0_0000;
      res_inv = 1'b1;
    end else if (b_zero) begin
      res_q  = {sgn, 8'hFF, 23'd0};
      res_dz = 1'b1;
    end else if (a_inf) begin
      res_q = {sgn, 8'hFF, 23'd0};
    end else if (a_zero || b_inf) begin
      res_q = {sgn, 31'd0};
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    inv_d   = inv_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = 4'(RECIP_WAIT);
          dz_d    = 1'b0;
          inv_d   = 1'b0;
          state_d = StRecip;
        end
      end
      StRecip: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          r_d     = recip;
          state_d = StMul;
        end
      end
      StMul: begin
        q_d     = res_q;
        dz_d    = res_dz;
        inv_d   = res_inv;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      inv_q   <= inv_d;
    end
  end

  assign in_ready  = state_q == StIdle;
  assign out_valid = state_q == StDone;
  assign q         = q_q;
  assign flag_dz   = dz_q;
  assign flag_inv  = inv_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq: expected results queued at accept, checked at the output
// handshake. A second instance with RECIP_WAIT=2 covers the multicycle latency.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid0 = 1'b0, out_ready0 = 1'b1;
  logic [31:0] a0 = '0, b0 = '0;
  logic        in_ready0, out_valid0, flag_dz0, flag_inv0;
  logic [31:0] q0;
  logic        in_valid2 = 1'b0, out_ready2 = 1'b1;
  logic [31:0] a2 = '0, b2 = '0;
  logic        in_ready2, out_valid2, flag_dz2, flag_inv2;
  logic [31:0] q2;

  always #5 clk = ~clk;

  fp_div_seq #(.RECIP_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .a(a0), .b(b0),
    .out_valid(out_valid0), .out_ready(out_ready0), .q(q0), .flag_dz(flag_dz0),
    .flag_inv(flag_inv0)
  );

  fp_div_seq #(.RECIP_WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .out_valid(out_valid2), .out_ready(out_ready2), .q(q2), .flag_dz(flag_dz2),
    .flag_inv(flag_inv2)
  );

  typedef struct {
    logic [31:0] q;
    logic        dz;
    logic        inv;
    int          tol;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ulp_dist(input logic [31:0] x, input logic [31:0] y);
    int dx, dy;
    if (x[31] != y[31]) return 1 << 30;
    dx = int'({1'b0, x[30:0]});
    dy = int'({1'b0, y[30:0]});
    return (dx > dy) ? dx - dy : dy - dx;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid0) begin
      if (sb.size() == 0) begin
        check_val("spurious_out_valid", 32'd1, 32'd0);
      end else if (out_ready0) begin
        exp_t e;
        e = sb.pop_front();
        if (e.tol > 0) begin
          check_val($sformatf("q_within_ulp got=%h want=%h", q0, e.q),
                    32'(ulp_dist(q0, e.q) <= e.tol), 32'd1);
        end else begin
          check_val("q_exact", q0, e.q);
        end
        check_val("flag_dz", flag_dz0, e.dz);
        check_val("flag_inv", flag_inv0, e.inv);
      end
    end
  end

  // All stimulus tasks are entered and left 1 time unit after a rising edge.
  task automatic send0(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] eq,
                       input logic edz, input logic einv, input int tol);
    int n = 0;
    while (!in_ready0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready0) check_val("send_timeout", 32'd0, 32'd1);
    a0 = av;
    b0 = bv;
    in_valid0 = 1'b1;
    sb.push_back('{q: eq, dz: edz, inv: einv, tol: tol});
    @(posedge clk); #1;
    in_valid0 = 1'b0;
  endtask

  task automatic wait_out0(output int n);
    n = 1;
    while (!out_valid0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic wait_idle0();
    int n = 0;
    while ((!in_ready0 || sb.size() != 0) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check_val("idle_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] t2a[4];
  logic [31:0] t2b[4];
  logic [31:0] t2q[4];
  logic        t2dz[4];
  logic        t2inv[4];

  initial begin
    int n;
    t2a   = '{32'h3F80_0000, 32'h8000_0000, 32'h7F80_0000, 32'hC000_0000};
    t2b   = '{32'h0000_0000, 32'h0000_0000, 32'hFF80_0000, 32'h7F80_0000};
    t2q   = '{32'h7F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h8000_0000};
    t2dz  = '{1'b1, 1'b0, 1'b0, 1'b0};
    t2inv = '{1'b0, 1'b1, 1'b1, 1'b0};

    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("rst_in_ready", in_ready0, 1'b1);
    check_val("rst_out_valid", out_valid0, 1'b0);
    check_val("rst_q", q0, 32'd0);
    check_val("rst_flags", {flag_dz0, flag_inv0}, 2'b00);
    check_val("rst_in_ready2", in_ready2, 1'b1);
    check_val("rst_out_valid2", out_valid2, 1'b0);

    // Basic quotient and handshake timing.
    send0(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 2);
    wait_out0(n);
    check_val("t1_latency", n, 3);
    check_val("t1_in_ready_done", in_ready0, 1'b0);
    @(posedge clk); #1;
    check_val("t1_in_ready_after", in_ready0, 1'b1);
    check_val("t1_out_valid_after", out_valid0, 1'b0);

    // Special operands back to back.
    for (int i = 0; i < 4; i++) begin
      send0(t2a[i], t2b[i], t2q[i], t2dz[i], t2inv[i], 0);
      if (i == 2) check_val("t2_dz_cleared", flag_dz0, 1'b0);
      if (i == 3) check_val("t2_inv_cleared", flag_inv0, 1'b0);
      wait_idle0();
    end

    // Backpressure: result held, new operands ignored, one-cycle out_ready completes it.
    out_ready0 = 1'b0;
    send0(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 1'b0, 1'b0, 0);
    wait_out0(n);
    for (int k = 0; k < 5; k++) begin
      check_val("t3_out_valid", out_valid0, 1'b1);
      check_val("t3_q_stable", q0, 32'h3F00_0000);
      check_val("t3_in_ready", in_ready0, 1'b0);
      a0 = 32'h4000_0000;
      b0 = 32'h3F80_0000;
      in_valid0 = (k % 2 == 0);
      @(posedge clk); #1;
    end
    in_valid0 = 1'b0;
    check_val("t3_out_valid_end", out_valid0, 1'b1);
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    out_ready0 = 1'b0;
    check_val("t3_in_ready_after", in_ready0, 1'b1);
    check_val("t3_out_valid_after", out_valid0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    check_val("t3_still_idle", in_ready0, 1'b1);
    out_ready0 = 1'b1;

    // Reset while in RECIP: immediate clear, no result.
    send0(32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 0);
    rst = 1'b1;
    #1;
    check_val("t4_q_zero", q0, 32'd0);
    check_val("t4_out_valid", out_valid0, 1'b0);
    check_val("t4_in_ready", in_ready0, 1'b1);
    check_val("t4_flags", {flag_dz0, flag_inv0}, 2'b00);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_val("t4_no_out_valid", out_valid0, 1'b0);
    end
    send0(32'h3F80_0000, 32'h4080_0000, 32'h3E80_0000, 1'b0, 1'b0, 2);
    wait_idle0();

    // RECIP_WAIT=2 instance.
    a2 = 32'h4120_0000;
    b2 = 32'h40A0_0000;
    in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    n = 1;
    while (!out_valid2 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_val("t5_latency", n, 5);
    check_val($sformatf("t5_q_within_ulp got=%h", q2), 32'(ulp_dist(q2, 32'h4000_0000) <= 2),
              32'd1);
    check_val("t5_flags", {flag_dz2, flag_inv2}, 2'b00);
    @(posedge clk); #1;
    check_val("t5_in_ready_after", in_ready2, 1'b1);

    // Sign handling and denormal divisor flushed to zero.
    send0(32'hBF80_0000, 32'h4040_0000, 32'hBEAA_AAAB, 1'b0, 1'b0, 2);
    wait_idle0();
    send0(32'h3F80_0000, 32'h0000_0001, 32'h7F80_0000, 1'b1, 1'b0, 0);
    wait_idle0();

    check_val("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
